// File: rtl/demux_pkg.sv
// demux_pkg: constants shared by demux_stream and its channel buffers.
// The transfer counters exist only when DEMUX_STREAM_CNT_EN is defined.
package demux_pkg;

    localparam int unsigned      CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    // Saturating increment: holds at CNT_MAX instead of wrapping.
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/demux_chan_buf.sv
// demux_chan_buf: one-entry output buffer for a single demux channel.
// Optional transfer counter when DEMUX_STREAM_CNT_EN is defined.
module demux_chan_buf
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] wdata,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] rdata
`ifdef DEMUX_STREAM_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt
`endif
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // A load wins over a drain, so drain+load keeps the entry full with the new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= wdata;
        end else if (ready) begin
            valid_q <= 1'b0;
        end
    end

    assign valid = valid_q;
    assign rdata = data_q;

`ifdef DEMUX_STREAM_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Count completed output transfers, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (valid_q && ready) begin
            cnt_q <= cnt_sat_inc(cnt_q);
        end
    end

    assign cnt = cnt_q;
`endif

endmodule

// File: rtl/demux_stream.sv
// demux_stream: routes a valid/ready input stream to one of NCH buffered
// output channels chosen by sel. Out-of-range selects are dropped and flag
// the sticky err bit. Define DEMUX_STREAM_CNT_EN to add per-channel
// transfer counters on port cnt.
module demux_stream
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in,
    input  logic [SELW-1:0]      sel,
    output logic [NCH-1:0]       y_valid,
    input  logic [NCH-1:0]       y_ready,
    output logic [NCH*WIDTH-1:0] y,
`ifdef DEMUX_STREAM_CNT_EN
    output logic [NCH*CNT_W-1:0] cnt,
`endif
    output logic                 err
);

    logic [NCH-1:0] ch_open;
    logic [NCH-1:0] load;
    logic           sel_oob;
    logic           err_q;

    assign sel_oob = (32'(sel) >= NCH);

    // Steer the accept to the selected channel; out-of-range selects always accept.
    always_comb begin
        in_ready = 1'b1;
        load     = '0;
        for (int k = 0; k < NCH; k++) begin
            if (sel == SELW'(k)) begin
                in_ready = ch_open[k];
                load[k]  = in_valid && ch_open[k];
            end
        end
    end

    // Sticky error on any offered word with an out-of-range select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (in_valid && sel_oob) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        // A channel can take a word when empty or being drained this cycle.
        assign ch_open[k] = !y_valid[k] || y_ready[k];

        demux_chan_buf #(
            .WIDTH(WIDTH)
        ) u_buf (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[k]),
            .wdata (in),
            .valid (y_valid[k]),
            .ready (y_ready[k]),
            .rdata (y[k*WIDTH +: WIDTH])
`ifdef DEMUX_STREAM_CNT_EN
            ,
            .cnt   (cnt[k*CNT_W +: CNT_W])
`endif
        );
    end

endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: self-checking bench for demux_stream (NCH=4 and NCH=3
// instances). Counter checks are compiled in with DEMUX_STREAM_CNT_EN.
module tb_demux_stream;

    localparam int W = 8;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // NCH=4 instance
    logic           in_valid, in_ready, err;
    logic [W-1:0]   din;
    logic [1:0]     sel;
    logic [N-1:0]   y_valid, y_ready;
    logic [N*W-1:0] y;

    // NCH=3 instance
    logic           iv3, rdy3, err3;
    logic [W-1:0]   in3;
    logic [1:0]     sel3;
    logic [2:0]     yv3, yr3;
    logic [3*W-1:0] y3;

`ifdef DEMUX_STREAM_CNT_EN
    logic [N*16-1:0] cnt;
    logic [3*16-1:0] cnt3;
`endif

    demux_stream #(.WIDTH(W), .NCH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in       (din),
        .sel      (sel),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .y        (y),
`ifdef DEMUX_STREAM_CNT_EN
        .cnt      (cnt),
`endif
        .err      (err)
    );

    demux_stream #(.WIDTH(W), .NCH(3)) dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (iv3),
        .in_ready (rdy3),
        .in       (in3),
        .sel      (sel3),
        .y_valid  (yv3),
        .y_ready  (yr3),
        .y        (y3),
`ifdef DEMUX_STREAM_CNT_EN
        .cnt      (cnt3),
`endif
        .err      (err3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one full clock; inputs are always changed just after a falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0; sel = '0; din = '0; y_ready = '1;
        iv3 = 1'b0; sel3 = '0; in3 = '0; yr3 = '1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       iv;
        logic [1:0] sel;
        logic [7:0] din;
        logic [3:0] yr;
        logic       erdy;
        logic [3:0] eyv;
        logic       chk_y;
        int         ych;
        logic [7:0] ey;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic iv, input logic [1:0] s, input logic [7:0] d,
                                input logic [3:0] yr, input logic erdy, input logic [3:0] eyv,
                                input logic chk_y, input int ych, input logic [7:0] ey);
        vec_t v;
        v.iv = iv; v.sel = s; v.din = d; v.yr = yr; v.erdy = erdy; v.eyv = eyv;
        v.chk_y = chk_y; v.ych = ych; v.ey = ey;
        tbl.push_back(v);
    endfunction

    // Reference model: each channel is a FIFO of capacity one.
    logic [7:0] mq[N][$];
    int         mcnt[N];
    logic       exp_rdy;

    initial begin
        idle();
        rst_n = 1'b0;
        y_ready = '0;
        @(negedge clk);
        #1;
        // Reset state, with y_ready low so a stale full buffer would block.
        chk("rst y_valid", y_valid, 4'b0000);
        chk("rst y", y, 32'h0);
        chk("rst err", err, 1'b0);
        chk("rst in_ready", in_ready, 1'b1);
        chk("rst err3", err3, 1'b0);
`ifdef DEMUX_STREAM_CNT_EN
        chk("rst cnt", cnt, 64'h0);
`endif
        rst_n = 1'b1;
        idle();
        cyc();

        // Directed vector table, applied from empty.
        add(1, 2, 8'hA5, 4'hF, 1, 4'b0000, 0, 0, 8'h00);
        add(0, 0, 8'h00, 4'hF, 1, 4'b0100, 1, 2, 8'hA5);
        add(0, 0, 8'h00, 4'hF, 1, 4'b0000, 0, 0, 8'h00);
        add(1, 1, 8'h11, 4'hD, 1, 4'b0000, 0, 0, 8'h00);
        add(1, 1, 8'h22, 4'hD, 0, 4'b0010, 1, 1, 8'h11);
        add(1, 1, 8'h22, 4'hD, 0, 4'b0010, 1, 1, 8'h11);
        add(1, 1, 8'h22, 4'hF, 1, 4'b0010, 1, 1, 8'h11);
        add(0, 0, 8'h00, 4'hF, 1, 4'b0010, 1, 1, 8'h22);
        add(0, 0, 8'h00, 4'hF, 1, 4'b0000, 0, 0, 8'h00);
        add(1, 0, 8'hC0, 4'hE, 1, 4'b0000, 0, 0, 8'h00);
        add(1, 3, 8'h33, 4'hE, 1, 4'b0001, 1, 0, 8'hC0);
        add(0, 0, 8'h00, 4'hE, 0, 4'b1001, 1, 3, 8'h33);
        add(0, 0, 8'h00, 4'hF, 1, 4'b0001, 1, 0, 8'hC0);
        add(1, 0, 8'h01, 4'hF, 1, 4'b0000, 0, 0, 8'h00);
        add(1, 0, 8'h02, 4'hF, 1, 4'b0001, 1, 0, 8'h01);
        add(1, 0, 8'h03, 4'hF, 1, 4'b0001, 1, 0, 8'h02);
        add(0, 0, 8'h00, 4'hF, 1, 4'b0001, 1, 0, 8'h03);
        add(0, 0, 8'h00, 4'hF, 1, 4'b0000, 0, 0, 8'h00);

        foreach (tbl[i]) begin
            in_valid = tbl[i].iv; sel = tbl[i].sel; din = tbl[i].din; y_ready = tbl[i].yr;
            #1;
            chk($sformatf("vec%0d in_ready", i), in_ready, tbl[i].erdy);
            chk($sformatf("vec%0d y_valid", i), y_valid, tbl[i].eyv);
            if (tbl[i].chk_y)
                chk($sformatf("vec%0d y[%0d]", i, tbl[i].ych), y[tbl[i].ych*8 +: 8], tbl[i].ey);
            cyc();
        end
        idle();

        // Asynchronous reset while channels hold data.
        y_ready = '0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; sel = 2'(k); din = 8'(8'h60 + k);
            cyc();
        end
        in_valid = 1'b0;
        #1;
        chk("pre-async y_valid", y_valid, 4'b0111);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async y_valid", y_valid, 4'b0000);
        chk("async y", y, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; sel = 2'd1; din = 8'h5A; y_ready = '0;
        #1;
        chk("post-rst in_ready", in_ready, 1'b1);
        cyc();
        in_valid = 1'b0;
        #1;
        chk("post-rst y_valid", y_valid, 4'b0010);
        chk("post-rst y[1]", y[15:8], 8'h5A);
        idle();
        cyc();

        // NCH=3: out-of-range select.
        sel3 = 2'd3;
        #1;
        chk("nch3 oob idle in_ready", rdy3, 1'b1);
        cyc();
        chk("nch3 err no valid", err3, 1'b0);
        iv3 = 1'b1; in3 = 8'h77; yr3 = '0;
        #1;
        chk("nch3 oob in_ready", rdy3, 1'b1);
        cyc();
        iv3 = 1'b0;
        #1;
        chk("nch3 err set", err3, 1'b1);
        chk("nch3 dropped", yv3, 3'b000);
        repeat (3) cyc();
        chk("nch3 err sticky", err3, 1'b1);
        iv3 = 1'b1; sel3 = 2'd2; in3 = 8'h44; yr3 = '1;
        #1;
        chk("nch3 ch2 in_ready", rdy3, 1'b1);
        cyc();
        iv3 = 1'b0;
        #1;
        chk("nch3 ch2 y_valid", yv3, 3'b100);
        chk("nch3 ch2 y", y3[23:16], 8'h44);
        chk("nch3 err still", err3, 1'b1);
        idle();
        do_reset();
        #1;
        chk("nch3 err cleared", err3, 1'b0);

        // Randomized run against the queue model.
        for (int k = 0; k < N; k++) begin
            mq[k].delete();
            mcnt[k] = 0;
        end
        do_reset();
        for (int it = 0; it < 3000; it++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            sel = 2'($urandom);
            din = 8'($urandom);
            y_ready = 4'($urandom);
            #1;
            exp_rdy = (mq[sel].size() == 0) || y_ready[sel];
            chk($sformatf("rnd%0d in_ready", it), in_ready, exp_rdy);
            for (int k = 0; k < N; k++) begin
                chk($sformatf("rnd%0d y_valid[%0d]", it, k), y_valid[k], mq[k].size() != 0);
                if (mq[k].size() != 0)
                    chk($sformatf("rnd%0d y[%0d]", it, k), y[k*8 +: 8], mq[k][0]);
`ifdef DEMUX_STREAM_CNT_EN
                chk($sformatf("rnd%0d cnt[%0d]", it, k), cnt[k*16 +: 16], 16'(mcnt[k]));
`endif
            end
            @(posedge clk);
            for (int k = 0; k < N; k++) begin
                if (mq[k].size() != 0 && y_ready[k]) begin
                    void'(mq[k].pop_front());
                    if (mcnt[k] < 65535) mcnt[k]++;
                end
            end
            if (in_valid && exp_rdy) mq[sel].push_back(din);
            @(negedge clk);
        end
        idle();

`ifdef DEMUX_STREAM_CNT_EN
        // Counter saturation on channel 0.
        do_reset();
        #1;
        chk("cnt after reset", cnt, 64'h0);
        in_valid = 1'b1; sel = 2'd0; y_ready = '1;
        for (int i = 0; i < 65540; i++) begin
            din = 8'(i);
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        cyc();
        chk("cnt0 saturated", cnt[15:0], 16'hFFFF);
        chk("cnt others", cnt[63:16], 48'h0);
        do_reset();
        #1;
        chk("cnt cleared", cnt, 64'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/demux_stream.md
DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning payload bits per transfer.
REQ-002 SHALL have parameter NCH, default 4, meaning output channel count (2..16).
REQ-003 SHALL have parameter SELW, default $clog2(NCH), meaning select width.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  meaning asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  meaning input transfer offered.
REQ-007 SHALL have port in_ready  output  1  meaning input transfer accepted this cycle.
REQ-008 SHALL have port in  input  WIDTH  meaning input payload.
REQ-009 SHALL have port sel  input  SELW  meaning destination channel for the current input.
REQ-010 SHALL have port y_valid  output  NCH  meaning per-channel output valid.
REQ-011 SHALL have port y_ready  input  NCH  meaning per-channel downstream ready.
REQ-012 SHALL have port y  output  NCH*WIDTH  meaning channel k payload on bits [k*WIDTH +: WIDTH].
REQ-013 SHALL have port err  output  1  meaning sticky flag, set on an out-of-range select.

Function
REQ-014 SHALL accept an input transfer when in_valid && in_ready are both high at a rising edge.
REQ-015 SHALL give each channel a one-entry output buffer; an accepted transfer loads buffer[sel] with in and sets y_valid[sel] on the next edge (latency 1 cycle).
REQ-016 SHALL drive in_ready = !y_valid[sel] || y_ready[sel] when sel < NCH, i.e. a full buffer being drained accepts a new word in the same cycle.
REQ-017 SHALL allow in_ready to depend combinationally on sel and y_ready, but never on in_valid.
REQ-018 SHALL complete a channel-k output transfer when y_valid[k] && y_ready[k]; with no reload, y_valid[k] clears on that edge.
REQ-019 SHALL on simultaneous drain and load of the same channel keep y_valid[k]=1 and replace the payload with the new word.
REQ-020 SHALL hold y[k] and y_valid[k] stable while y_valid[k]=1 and y_ready[k]=0.
REQ-021 SHALL keep channels independent: a stalled channel never blocks transfers addressed to other channels.
REQ-022 SHALL, when sel >= NCH (non-power-of-two NCH only), drive in_ready=1, discard the word, and set err on that edge if in_valid=1.
REQ-023 SHALL leave y_valid unaffected by any input while in_valid=0.

Reset
REQ-024 SHALL on rst_n=0 immediately clear y_valid to all zeros, y to all zeros and err to 0, regardless of clk.
REQ-025 SHALL discard any buffered words if reset is asserted mid-operation; the first transfer after release behaves as from empty.
REQ-026 SHALL drive in_ready per REQ-016 with all buffers empty during reset, so in_ready=1.

Configuration
REQ-027 SHALL implement per-channel transfer counters when macro DEMUX_STREAM_CNT_EN is defined.
REQ-028 SHALL with DEMUX_STREAM_CNT_EN add output port cnt  NCH*16, where cnt[k] increments on each channel-k output transfer, saturates at 16'hFFFF, and resets to 0.
REQ-029 SHALL without DEMUX_STREAM_CNT_EN omit the cnt port and counters entirely, with all other behaviour unchanged.

Structure
REQ-030 SHALL place the counter width constant (16) and its saturation value in shared package demux_pkg.
REQ-031 SHALL implement the per-channel buffer as sub-module demux_chan_buf (WIDTH parameter; load, data, valid, ready, optional counter), instantiated NCH times via generate.

Verification
REQ-032 SHALL cover: reset, then in=8'hA5 and sel=2 with valid for one cycle, all y_ready=1 -> next cycle y_valid=4'b0100 with y[2]=8'hA5, followed by y_valid=0.
REQ-033 SHALL cover: y_ready[1]=0, two words 8'h11 then 8'h22 to sel=1 -> first accepted, in_ready=0 on the second until y_ready[1]=1, after which y[1] shows 8'h11 then 8'h22 in order.
REQ-034 SHALL cover: channel 0 stalled and full, word 8'h33 to sel=3 -> in_ready=1 and y[3]=8'h33 on the next cycle.
REQ-035 SHALL cover: back-to-back writes to sel=0 with y_ready[0]=1 -> one word per cycle, y_valid[0] continuously 1.
REQ-036 SHALL cover: NCH=3, sel=3 with in_valid=1 -> word dropped, in_ready=1, err=1 and sticky until reset.
REQ-037 SHALL cover: rst_n pulsed low while channels hold data -> y_valid=0 asynchronously; with DEMUX_STREAM_CNT_EN, cnt is 0 and saturates at 16'hFFFF after 65536+ transfers.
